// File: rtl/mouse_shot_ctrl.sv
// Cursor clamp and left-click shot issuer with valid/ready handoff and post-shot cooldown.
// Optional build macro MOUSE_SHOT_DROP_CNT_EN adds a saturating count of dropped presses.
module mouse_shot_ctrl #(
  parameter int H_MAX        = 1023,
  parameter int V_MAX        = 767,
  parameter int COOLDOWN_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        left_in,
  output logic [11:0] cursor_x,
  output logic [11:0] cursor_y,
  output logic        shot_valid,
  input  logic        shot_ready,
  output logic [11:0] shot_x,
  output logic [11:0] shot_y,
`ifdef MOUSE_SHOT_DROP_CNT_EN
  output logic [7:0]  shot_drop_cnt,
`endif
  output logic        busy
);

  localparam logic [11:0] H_LIM = 12'(H_MAX);
  localparam logic [11:0] V_LIM = 12'(V_MAX);
  localparam int          CNT_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (COOLDOWN_CYC == 0) ? '0 : CNT_W'(COOLDOWN_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;

  function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_left_q;
  logic [11:0]      r_cursor_x, r_cursor_y, r_shot_x, r_shot_y;
  logic [11:0]      w_cx, w_cy;
  logic             w_press;

  assign w_cx    = clamp12(xpos_in, H_LIM);
  assign w_cy    = clamp12(ypos_in, V_LIM);
  assign w_press = left_in & ~r_left_q;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (w_press) w_state_nxt = ISSUE;
      ISSUE:    if (shot_ready) w_state_nxt = (COOLDOWN_CYC == 0) ? IDLE : COOLDOWN;
      COOLDOWN: if (r_cnt == '0) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // left_q resets high so a button held through reset release is not seen as a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_left_q   <= 1'b1;
      r_cursor_x <= '0;
      r_cursor_y <= '0;
      r_shot_x   <= '0;
      r_shot_y   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_left_q   <= left_in;
      r_cursor_x <= w_cx;
      r_cursor_y <= w_cy;
      if (r_state == IDLE && w_press) begin
        r_shot_x <= w_cx;
        r_shot_y <= w_cy;
      end
      if (r_state == ISSUE && shot_ready)
        r_cnt <= CNT_INIT;
      else if (r_state == COOLDOWN && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

`ifdef MOUSE_SHOT_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop = w_press && (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF)
      r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign shot_drop_cnt = r_drop_cnt;
`endif

  // shot_valid derives from state so asynchronous reset drops it without a clock edge
  assign shot_valid = (r_state == ISSUE);
  assign busy       = (r_state != IDLE);
  assign cursor_x   = r_cursor_x;
  assign cursor_y   = r_cursor_y;
  assign shot_x     = r_shot_x;
  assign shot_y     = r_shot_y;

endmodule

// File: tb/tb_mouse_shot_ctrl.sv
// Directed bench for mouse_shot_ctrl: clamp vector table plus shot, stall, cooldown and reset sequences.
// Honours MOUSE_SHOT_DROP_CNT_EN when the design is built with it.
module tb_mouse_shot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] xpos_in, ypos_in;
  logic        left_in, shot_ready;
  logic [11:0] cursor_x, cursor_y, shot_x, shot_y;
  logic        shot_valid, busy;
`ifdef MOUSE_SHOT_DROP_CNT_EN
  logic [7:0]  shot_drop_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mouse_shot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .xpos_in(xpos_in), .ypos_in(ypos_in), .left_in(left_in),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .shot_valid(shot_valid), .shot_ready(shot_ready),
    .shot_x(shot_x), .shot_y(shot_y),
`ifdef MOUSE_SHOT_DROP_CNT_EN
    .shot_drop_cnt(shot_drop_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] ex;
    logic [11:0] ey;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    bit done;

    tbl[0] = '{12'd2000, 12'd900,  12'd1023, 12'd767};
    tbl[1] = '{12'd5,    12'd900,  12'd5,    12'd767};
    tbl[2] = '{12'd1023, 12'd767,  12'd1023, 12'd767};
    tbl[3] = '{12'd1024, 12'd768,  12'd1023, 12'd767};
    tbl[4] = '{12'd0,    12'd0,    12'd0,    12'd0};
    tbl[5] = '{12'd4095, 12'd4095, 12'd1023, 12'd767};
    tbl[6] = '{12'd1022, 12'd766,  12'd1022, 12'd766};
    tbl[7] = '{12'd300,  12'd200,  12'd300,  12'd200};

    // Reset with button held; ready high while idle must be ignored
    rst_n = 1'b0; left_in = 1'b1; shot_ready = 1'b1; xpos_in = 12'd0; ypos_in = 12'd0;
    step(); step();
    chk("rst_valid", shot_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cursor_x", cursor_x, 0);
    chk("rst_shot_x", shot_x, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (shot_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("held_no_shot", bad, 0);

    // Clamp table, button released so no press occurs
    left_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xpos_in = tbl[i].x; ypos_in = tbl[i].y;
      step();
      chk($sformatf("clamp_x[%0d]", i), cursor_x, tbl[i].ex);
      chk($sformatf("clamp_y[%0d]", i), cursor_y, tbl[i].ey);
    end
    chk("clamp_idle_busy", busy, 0);

    // Press at (300,200) with ready high: one-cycle valid then 16 cycles cooldown
    left_in = 1'b1;
    step();
    chk("shot1_valid", shot_valid, 1);
    chk("shot1_x", shot_x, 300);
    chk("shot1_y", shot_y, 200);
    left_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (shot_valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("cooldown_16", bad, 0);
    step();
    chk("cooldown_end_busy", busy, 0);

    // Stalled consumer while cursor moves; one press during ISSUE is dropped
    shot_ready = 1'b0;
    left_in = 1'b1;
    step();
    chk("shot2_valid", shot_valid, 1);
    xpos_in = 12'd400; ypos_in = 12'd100;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      left_in = (i == 4) ? 1'b0 : 1'b1;
      step();
      if (shot_valid !== 1'b1 || shot_x !== 12'd300 || shot_y !== 12'd200) bad++;
    end
    chk("stall_hold", bad, 0);
    chk("stall_cursor_x", cursor_x, 400);
    chk("stall_cursor_y", cursor_y, 100);
    shot_ready = 1'b1;
    step();
    chk("stall_release_valid", shot_valid, 0);
    chk("stall_release_busy", busy, 1);

    // Press five cycles into cooldown is dropped
    left_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    left_in = 1'b1;
    step();
    chk("cd_press_valid", shot_valid, 0);
    chk("cd_press_shot_x", shot_x, 300);
    left_in = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (busy == 1'b0) done = 1'b1;
      else if (shot_valid !== 1'b0) bad++;
    end
    chk("cd_exit_in_budget", done, 1);
`ifdef MOUSE_SHOT_DROP_CNT_EN
    chk("drop_cnt", shot_drop_cnt, 2);
`endif

    // Fresh press after idle is accepted; hold it pending for the reset test
    shot_ready = 1'b0;
    left_in = 1'b1;
    step();
    chk("shot3_valid", shot_valid, 1);
    chk("shot3_x", shot_x, 400);
    chk("shot3_y", shot_y, 100);

    // Asynchronous reset mid-transaction
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", shot_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_shot_x", shot_x, 0);
    chk("async_cursor_x", cursor_x, 0);
`ifdef MOUSE_SHOT_DROP_CNT_EN
    chk("async_drop_cnt", shot_drop_cnt, 0);
`endif
    xpos_in = 12'd0; ypos_in = 12'd0;
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (shot_valid !== 1'b0 || busy !== 1'b0 || shot_x !== 12'd0 || shot_y !== 12'd0 ||
          cursor_x !== 12'd0 || cursor_y !== 12'd0) bad++;
    end
    chk("post_reset_idle", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
